fetch_queue: RTL

Show-ahead instruction FIFO between the icache response path and the IF/ID pipeline register. Each entry buffers one fetched instruction with its PC and branch-prediction metadata. Decode side drains the queue, so an icache hit is never lost when decode stalls. Flush (misprediction redirect) empties the queue and discards one stale in-flight icache response.

---
 rtl/fetch_queue.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Show-ahead instruction queue between the icache response path and IF/ID.
// Flush empties the queue and can arm a one-shot discard of a stale in-flight response.
module fetch_queue #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             fetch_busy_i,
  input  logic             push_i,
  input  logic [31:0]      push_pc_i,
  input  logic [31:0]      push_instr_i,
  input  logic             push_btb_hit_i,
  input  logic [1:0]       push_pred_outcome_i,
  input  logic [31:0]      push_pred_pc_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      instr_o,
  output logic             btb_hit_o,
  output logic [1:0]       pred_outcome_o,
  output logic [31:0]      pred_pc_o,
  output logic [PTR_W:0]   count_o,
  output logic             overflow_o
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        btb_hit;
    logic [1:0]  pred_outcome;
    logic [31:0] pred_pc;
  } entry_t;

  localparam entry_t ENTRY_RST = '{pc: 32'h0, instr: 32'h0, btb_hit: 1'b0,
                                   pred_outcome: 2'b01, pred_pc: 32'h0};

  entry_t             mem [DEPTH];
  entry_t             head;
  entry_t             wr_entry;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               drop_q, drop_d;
  logic               overflow_q, overflow_d;
  logic               push_ok, pop_ok;

  assign ready_o = (count_q != FULL_CNT);
  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign overflow_o = overflow_q;

  assign push_ok = push_i & ready_o & ~flush_i & ~drop_q;
  assign pop_ok  = pop_i & valid_o & ~flush_i;

  assign wr_entry = '{pc: push_pc_i, instr: push_instr_i, btb_hit: push_btb_hit_i,
                      pred_outcome: push_pred_outcome_i, pred_pc: push_pred_pc_i};

  // Head fields are read straight out of storage; no write-to-read bypass.
  assign head           = mem[rd_ptr_q];
  assign pc_o           = head.pc;
  assign instr_o        = head.instr;
  assign btb_hit_o      = head.btb_hit;
  assign pred_outcome_o = head.pred_outcome;
  assign pred_pc_o      = head.pred_pc;

  // Next-state for pointers, occupancy, stale-drop and overflow flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      // A push arriving with the flush is the stale response itself.
      drop_d   = (drop_q | fetch_busy_i) & ~push_i;
    end else begin
      if (drop_q && push_i) drop_d = 1'b0;
      if (push_i && !drop_q && !ready_o) overflow_d = 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ENTRY_RST;
    end else if (push_ok) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

endmodule
